acc_mem_responder: RTL and testbench

- Memory-side responder for the accelerator arbiter's downstream port.
- Accepts one held-level read request (fetches a 512-bit line) or one held-level write request (one 32-bit word) at a time.
- Executes requests against a single-port 32-bit-wide data SRAM with fixed read latency.
- Returns mem_acc_read_data_valid / mem_acc_write_done pulses, completing the handshake the arbiter and accelerators initiate.

---
 rtl/acc_mem_pkg.sv | 20 ++
 rtl/acc_line_assembler.sv | 58 +++++
 rtl/acc_mem_responder.sv | 156 +++++++++++++++
 tb/tb_acc_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accelerator memory responder.
package acc_mem_pkg;

    localparam int unsigned WordSize       = 32;
    localparam int unsigned LineSize       = 512;
    localparam int unsigned WORDS_PER_LINE = LineSize / WordSize;
    localparam int unsigned LINE_IDX_BITS  = $clog2(WORDS_PER_LINE);

    typedef logic [LineSize-1:0] line_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdDrain,
        StRdResp,
        StWr,
        StWrResp
    } resp_state_t;

endpackage

// File: rtl/acc_line_assembler.sv
// Collects SRAM read words into a line, one word per latency-delayed valid slot.
// RESP_LINE_CACHE_EN adds a word write port so cached lines can be written through.
module acc_line_assembler #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned SRAM_RD_LAT    = 1,
    parameter int unsigned IDX_BITS       = $clog2(WORDS_PER_LINE)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                issue_i,
    input  logic [WORD_SIZE-1:0]                sram_rdata_i,
`ifdef RESP_LINE_CACHE_EN
    input  logic                                wr_en_i,
    input  logic [IDX_BITS-1:0]                 wr_idx_i,
    input  logic [WORD_SIZE-1:0]                wr_data_i,
`endif
    output logic [WORDS_PER_LINE*WORD_SIZE-1:0] line_o,
    output logic                                line_done_o
);

    logic [SRAM_RD_LAT-1:0]                vld_q, vld_d;
    logic [IDX_BITS-1:0]                   cnt_q, cnt_d;
    logic [WORDS_PER_LINE*WORD_SIZE-1:0]   line_q, line_d;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = issue_i;
        cnt_d    = cnt_q;
        line_d   = line_q;
        // Top stage set means sram_rdata holds the word issued SRAM_RD_LAT cycles ago.
        if (vld_q[SRAM_RD_LAT-1]) begin
            line_d[cnt_q*WORD_SIZE +: WORD_SIZE] = sram_rdata_i;
            cnt_d = cnt_q + 1'b1;
        end
`ifdef RESP_LINE_CACHE_EN
        if (wr_en_i) begin
            line_d[wr_idx_i*WORD_SIZE +: WORD_SIZE] = wr_data_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line_o      = line_q;
    assign line_done_o = vld_q[SRAM_RD_LAT-1] && (cnt_q == '1);

endmodule

// File: rtl/acc_mem_responder.sv
// Memory-side responder: serves one line read or one word write at a time from a 32-bit SRAM.
// Define RESP_LINE_CACHE_EN for a one-entry write-through line cache.
module acc_mem_responder
    import acc_mem_pkg::*;
#(
    parameter int unsigned ADDR_SIZE   = 16,
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned LINE_SIZE   = 512,
    parameter int unsigned SRAM_RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_acc_read_en,
    input  logic [ADDR_SIZE-1:0] mem_acc_read_addr,
    output logic [LINE_SIZE-1:0] mem_acc_read_data,
    output logic                 mem_acc_read_data_valid,
    input  logic                 mem_acc_write_en,
    input  logic [ADDR_SIZE-1:0] mem_acc_write_addr,
    input  logic [WORD_SIZE-1:0] mem_acc_write_data,
    output logic                 mem_acc_write_done,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [WORD_SIZE-1:0] sram_wdata,
    input  logic [WORD_SIZE-1:0] sram_rdata
);

    localparam int unsigned Wpl     = LINE_SIZE / WORD_SIZE;
    localparam int unsigned IdxBits = $clog2(Wpl);
    localparam logic [ADDR_SIZE-1:0] IdxMask = ADDR_SIZE'(Wpl - 1);

    resp_state_t          state_q, state_d;
    logic [IdxBits-1:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic                 issue;
    logic                 line_done;
    logic                 rd_hit;

`ifdef RESP_LINE_CACHE_EN
    logic [ADDR_SIZE-IdxBits-1:0] tag_q, tag_d;
    logic                         tag_vld_q, tag_vld_d;
    logic                         cache_wr;

    assign rd_hit   = tag_vld_q && (mem_acc_read_addr[ADDR_SIZE-1:IdxBits] == tag_q);
    assign cache_wr = (state_q == StWr) && tag_vld_q &&
                      (mem_acc_write_addr[ADDR_SIZE-1:IdxBits] == tag_q);

    always_comb begin
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        if (line_done) begin
            tag_d     = base_q[ADDR_SIZE-1:IdxBits];
            tag_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end
`else
    assign rd_hit = 1'b0;
`endif

    always_comb begin
        state_d                 = state_q;
        issue_cnt_d             = issue_cnt_q;
        base_d                  = base_q;
        issue                   = 1'b0;
        sram_en                 = 1'b0;
        sram_we                 = 1'b0;
        sram_addr               = '0;
        sram_wdata              = '0;
        mem_acc_read_data_valid = 1'b0;
        mem_acc_write_done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_acc_write_en) begin
                    state_d = StWr;
                end else if (mem_acc_read_en) begin
                    base_d      = mem_acc_read_addr & ~IdxMask;
                    issue_cnt_d = '0;
                    state_d     = rd_hit ? StRdResp : StRdIssue;
                end
            end
            StRdIssue: begin
                sram_en = 1'b1;
                // Base is line aligned, so OR-ing the index never carries out of the line.
                sram_addr   = base_q | ADDR_SIZE'(issue_cnt_q);
                issue       = 1'b1;
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == IdxBits'(Wpl - 1)) begin
                    state_d = StRdDrain;
                end
            end
            StRdDrain: begin
                if (line_done) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                mem_acc_read_data_valid = 1'b1;
                state_d                 = StIdle;
            end
            StWr: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = mem_acc_write_addr;
                sram_wdata = mem_acc_write_data;
                state_d    = StWrResp;
            end
            StWrResp: begin
                mem_acc_write_done = 1'b1;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            base_q      <= base_d;
        end
    end

    acc_line_assembler #(
        .WORD_SIZE      (WORD_SIZE),
        .WORDS_PER_LINE (Wpl),
        .SRAM_RD_LAT    (SRAM_RD_LAT),
        .IDX_BITS       (IdxBits)
    ) u_line_assembler (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_i      (issue),
        .sram_rdata_i (sram_rdata),
`ifdef RESP_LINE_CACHE_EN
        .wr_en_i      (cache_wr),
        .wr_idx_i     (mem_acc_write_addr[IdxBits-1:0]),
        .wr_data_i    (mem_acc_write_data),
`endif
        .line_o       (mem_acc_read_data),
        .line_done_o  (line_done)
    );

endmodule

// File: tb/tb_acc_mem_responder.sv
// Directed bench for acc_mem_responder: SRAM latency 1 and 3 instances, plus
// cache-hit checks when RESP_LINE_CACHE_EN is defined.
module tb_acc_mem_responder;
    import acc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en   [2];
    logic [15:0] rd_addr [2];
    logic [511:0] rd_data[2];
    logic        rd_vld  [2];
    logic        wr_en   [2];
    logic [15:0] wr_addr [2];
    logic [31:0] wr_data [2];
    logic        wr_done [2];
    logic        s_en    [2];
    logic        s_we    [2];
    logic [15:0] s_addr  [2];
    logic [31:0] s_wdata [2];

    logic [31:0] mem0 [65536];
    logic [31:0] mem1 [65536];
    logic [31:0] p0, p1a, p1b, p1c;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // SRAM models: latency 1 for instance 0, latency 3 for instance 1.
    always @(posedge clk) begin
        if (s_en[0] && s_we[0]) mem0[s_addr[0]] <= s_wdata[0];
        p0 <= mem0[s_addr[0]];
        if (s_en[1] && s_we[1]) mem1[s_addr[1]] <= s_wdata[1];
        p1a <= mem1[s_addr[1]];
        p1b <= p1a;
        p1c <= p1b;
    end

    acc_mem_responder #(.SRAM_RD_LAT(1)) u_dut0 (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mem_acc_read_en         (rd_en[0]),
        .mem_acc_read_addr       (rd_addr[0]),
        .mem_acc_read_data       (rd_data[0]),
        .mem_acc_read_data_valid (rd_vld[0]),
        .mem_acc_write_en        (wr_en[0]),
        .mem_acc_write_addr      (wr_addr[0]),
        .mem_acc_write_data      (wr_data[0]),
        .mem_acc_write_done      (wr_done[0]),
        .sram_en                 (s_en[0]),
        .sram_we                 (s_we[0]),
        .sram_addr               (s_addr[0]),
        .sram_wdata              (s_wdata[0]),
        .sram_rdata              (p0)
    );

    acc_mem_responder #(.SRAM_RD_LAT(3)) u_dut1 (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mem_acc_read_en         (rd_en[1]),
        .mem_acc_read_addr       (rd_addr[1]),
        .mem_acc_read_data       (rd_data[1]),
        .mem_acc_read_data_valid (rd_vld[1]),
        .mem_acc_write_en        (wr_en[1]),
        .mem_acc_write_addr      (wr_addr[1]),
        .mem_acc_write_data      (wr_data[1]),
        .mem_acc_write_done      (wr_done[1]),
        .sram_en                 (s_en[1]),
        .sram_we                 (s_we[1]),
        .sram_addr               (s_addr[1]),
        .sram_wdata              (s_wdata[1]),
        .sram_rdata              (p1c)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic line_t make_line(input logic [31:0] start);
        line_t l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = start + 32'(k);
        return l;
    endfunction

    task automatic check_idle_outputs(input int d);
        check("rst_rd_vld", rd_vld[d], 0);
        check("rst_wr_done", wr_done[d], 0);
        check("rst_sram_en", s_en[d], 0);
        check("rst_sram_we", s_we[d], 0);
        check("rst_sram_addr", s_addr[d], 0);
        check("rst_sram_wdata", s_wdata[d], 0);
        check("rst_rd_data", rd_data[d], 0);
    endtask

    // Request seen at the first posedge after it is driven (cycle 0); cycles counted at negedges.
    task automatic do_read(input int d, input logic [15:0] addr, input int exp_cyc,
                           input int exp_issue, output line_t data);
        int          cyc;
        int          n;
        logic [15:0] base;
        base = addr & 16'hFFF0;
        cyc  = 0;
        n    = 0;
        @(negedge clk);
        rd_en[d]   = 1'b1;
        rd_addr[d] = addr;
        while (!rd_vld[d] && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_en[d]) begin
                check("rd_sram_addr", s_addr[d], base + 16'(n));
                check("rd_sram_we", s_we[d], 0);
                n++;
            end
        end
        check("rd_pulse_cycle", cyc, exp_cyc);
        check("rd_issue_count", n, exp_issue);
        data     = rd_data[d];
        rd_en[d] = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [15:0] addr, input logic [31:0] data);
        int cyc;
        int we_cyc;
        cyc    = 0;
        we_cyc = -1;
        @(negedge clk);
        wr_en[d]   = 1'b1;
        wr_addr[d] = addr;
        wr_data[d] = data;
        while (!wr_done[d] && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (s_en[d] && s_we[d]) begin
                we_cyc = cyc;
                check("wr_sram_addr", s_addr[d], addr);
                check("wr_sram_wdata", s_wdata[d], data);
            end
        end
        check("wr_we_cycle", we_cyc, 1);
        check("wr_done_cycle", cyc, 2);
        wr_en[d] = 1'b0;
    endtask

    initial begin
        line_t data;
        line_t exp;
        int    cyc;
        int    done_cyc;
        logic  seen;

        for (int k = 0; k < 16; k++) begin
            mem0[16'h0100 + 16'(k)] = 32'hA000_0000 + 32'(k);
            mem0[16'h0200 + 16'(k)] = 32'hB000_0000 + 32'(k);
            mem1[16'h0000 + 16'(k)] = 32'hC000_0000 + 32'(k);
            mem1[16'h0010 + 16'(k)] = 32'hD000_0000 + 32'(k);
        end
        for (int d = 0; d < 2; d++) begin
            rd_en[d]   = 1'b0;
            rd_addr[d] = '0;
            wr_en[d]   = 1'b0;
            wr_addr[d] = '0;
            wr_data[d] = '0;
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0);
        check_idle_outputs(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Line read, non-aligned address.
        do_read(0, 16'h0105, 18, 16, data);
        check("rd_line_0100", data, make_line(32'hA000_0000));
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_vld[0]) seen = 1'b1;
        end
        check("rd_single_pulse", seen, 0);

        // Word write, then read of the same line.
        do_write(0, 16'h0203, 32'hDEAD_BEEF);
        do_read(0, 16'h0200, 18, 16, data);
        exp = make_line(32'hB000_0000);
        exp[3*32 +: 32] = 32'hDEAD_BEEF;
        check("rd_after_wr", data, exp);

        // Simultaneous requests: write first, read 18 cycles after return to idle.
        @(negedge clk);
        wr_en[0]   = 1'b1;
        wr_addr[0] = 16'h0204;
        wr_data[0] = 32'h1111_2222;
        rd_en[0]   = 1'b1;
        rd_addr[0] = 16'h0100;
        cyc        = 0;
        done_cyc   = -1;
        while (!rd_vld[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (wr_done[0]) begin
                done_cyc  = cyc;
                wr_en[0]  = 1'b0;
            end
        end
        check("both_wr_done_cycle", done_cyc, 2);
        check("both_rd_pulse_cycle", cyc, 21);
        check("both_rd_line", rd_data[0], make_line(32'hA000_0000));
        rd_en[0] = 1'b0;

        // Latency-3 instance, back-to-back reads.
        do_read(1, 16'h0000, 20, 16, data);
        check("lat3_line_0000", data, make_line(32'hC000_0000));
        do_read(1, 16'h0010, 20, 16, data);
        check("lat3_line_0010", data, make_line(32'hD000_0000));

        // Reset in cycle 8 of a read aborts it.
        @(negedge clk);
        rd_en[0]   = 1'b1;
        rd_addr[0] = 16'h0200;
        repeat (8) @(negedge clk);
        rst_n    = 1'b0;
        rd_en[0] = 1'b0;
        #1;
        check_idle_outputs(0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_vld[0] || s_en[0]) seen = 1'b1;
        end
        check("rst_no_activity", seen, 0);
        rst_n = 1'b1;
        do_read(0, 16'h0100, 18, 16, data);
        check("rd_after_rst", data, make_line(32'hA000_0000));

`ifdef RESP_LINE_CACHE_EN
        do_read(0, 16'h0100, 1, 0, data);
        check("cache_hit_line", data, make_line(32'hA000_0000));
        do_write(0, 16'h0101, 32'h1234_5678);
        check("cache_wt_sram", mem0[16'h0101], 32'h1234_5678);
        do_read(0, 16'h0108, 1, 0, data);
        exp = make_line(32'hA000_0000);
        exp[1*32 +: 32] = 32'h1234_5678;
        check("cache_hit_updated", data, exp);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
